// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/add/sub,
// iterative one-bit-per-cycle shifts and a shift-add multiplier with registered flags.
module alu_seq #(
    parameter int WIDTH     = 18,
    parameter int IMM_WIDTH = 6,
    parameter int SHW       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 imm_sel,
    output logic [WIDTH-1:0]     result,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // One extra counter bit so a count of WIDTH fits even when WIDTH is a power of two.
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_W = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_1 = CW'(1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;

    logic [WIDTH-1:0]     opnd_b;
    logic [CW-1:0]        shamt_raw;
    logic [CW-1:0]        shamt;
    logic                 is_sub;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum_ext;
    logic                 add_v;
    logic [WIDTH-1:0]     shift_next;
    logic [2*WIDTH-1:0]   mul_sum;

    logic                 fin_load;
    logic [WIDTH-1:0]     fin_result;
    logic                 fin_c;
    logic                 fin_v;

    assign in_ready = (state == IDLE);

    assign opnd_b    = imm_sel ? {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm} : src2;
    assign shamt_raw = {1'b0, opnd_b[SHW-1:0]};
    assign shamt     = (shamt_raw >= CNT_W) ? CNT_W : shamt_raw;

    // SUB reuses the adder as A + ~B + 1, so carry out doubles as no-borrow.
    assign is_sub  = (op == OP_SUB);
    assign b_eff   = is_sub ? ~opnd_b : opnd_b;
    assign sum_ext = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign add_v   = (src1[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != src1[WIDTH-1]);

    assign shift_next = (op_q == OP_SHL) ? {a_q[WIDTH-2:0], 1'b0}
                                         : {a_q[WIDTH-1], a_q[WIDTH-1:1]};
    assign mul_sum    = acc_q + (b_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    // Value and carry/overflow that get latched on the edge that enters DONE.
    always_comb begin
        fin_load   = 1'b0;
        fin_result = '0;
        fin_c      = 1'b0;
        fin_v      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            fin_load   = 1'b1;
                            fin_result = sum_ext[WIDTH-1:0];
                            fin_c      = sum_ext[WIDTH];
                            fin_v      = add_v;
                        end
                        OP_AND: begin
                            fin_load   = 1'b1;
                            fin_result = src1 & opnd_b;
                        end
                        OP_NAND: begin
                            fin_load   = 1'b1;
                            fin_result = ~(src1 & opnd_b);
                        end
                        OP_NOR: begin
                            fin_load   = 1'b1;
                            fin_result = ~(src1 | opnd_b);
                        end
                        OP_SHL, OP_SRA: begin
                            if (shamt == '0) begin
                                fin_load   = 1'b1;
                                fin_result = src1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q == CNT_1) begin
                    fin_load = 1'b1;
                    if (op_q == OP_MUL) begin
                        fin_result = mul_sum[WIDTH-1:0];
                        fin_v      = |mul_sum[2*WIDTH-1:WIDTH];
                    end else begin
                        fin_result = shift_next;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= op;
                        a_q     <= src1;
                        b_q     <= opnd_b;
                        mcand_q <= {{WIDTH{1'b0}}, src1};
                        acc_q   <= '0;
                        if (fin_load) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt_q <= (op == OP_MUL) ? CNT_W : shamt;
                        end
                    end
                end
                BUSY: begin
                    a_q     <= shift_next;
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    acc_q   <= mul_sum;
                    cnt_q   <= cnt_q - CNT_1;
                    if (cnt_q == CNT_1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (fin_load) begin
                result <= fin_result;
                flag_z <= (fin_result == '0);
                flag_n <= fin_result[WIDTH-1];
                flag_c <= fin_c;
                flag_v <= fin_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: every op class, latency, saturation,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_alu_seq;

    localparam int WIDTH     = 18;
    localparam int IMM_WIDTH = 6;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     src1;
    logic [WIDTH-1:0]     src2;
    logic [IMM_WIDTH-1:0] imm;
    logic                 imm_sel;
    logic [WIDTH-1:0]     result;
    logic                 flag_z;
    logic                 flag_n;
    logic                 flag_c;
    logic                 flag_v;
    logic                 out_valid;
    logic                 out_ready;

    int checks = 0;
    int errors = 0;
    int lat;
    logic seen_valid;

    alu_seq #(.WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request for exactly one edge, then scrambles the inputs to prove capture.
    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [IMM_WIDTH-1:0] i, input logic s);
        op       = o;
        src1     = a;
        src2     = b;
        imm      = i;
        imm_sel  = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = ~o;
        src1     = ~a;
        src2     = ~b;
        imm      = ~i;
    endtask

    task automatic waitValid(output int l);
        l = 1;
        while (!out_valid && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [IMM_WIDTH-1:0] i, input logic s,
                         input int exp_lat, input logic [WIDTH-1:0] exp_res, input logic [3:0] exp_zncv);
        int l;
        applyStimulus(o, a, b, i, s);
        waitValid(l);
        checkOutput({tag, "_latency"}, 36'(l), 36'(exp_lat));
        checkOutput({tag, "_result"}, 36'(result), 36'(exp_res));
        checkOutput({tag, "_zncv"}, 36'({flag_z, flag_n, flag_c, flag_v}), 36'(exp_zncv));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = OP_ADD;
        src1      = '0;
        src2      = '0;
        imm       = '0;
        imm_sel   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result", 36'(result), 36'h0);
        checkOutput("reset_zncv", 36'({flag_z, flag_n, flag_c, flag_v}), 36'h0);
        checkOutput("reset_out_valid", 36'(out_valid), 36'h0);
        checkOutput("reset_in_ready", 36'(in_ready), 36'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        runOp("add_wrap", OP_ADD, 18'h3FFFF, 18'h00001, 6'h00, 1'b0, 1, 18'h00000, 4'b1010);
        runOp("add_ovf",  OP_ADD, 18'h1FFFF, 18'h00001, 6'h00, 1'b0, 1, 18'h20000, 4'b0101);
        runOp("sub_imm",  OP_SUB, 18'h00005, 18'h12345, 6'b111110, 1'b1, 1, 18'h00007, 4'b0000);
        runOp("nand",     OP_NAND, 18'h0F0F0, 18'h3C3C3, 6'h00, 1'b0, 1, 18'h33F3F, 4'b0100);
        runOp("nor",      OP_NOR,  18'h0F0F0, 18'h3C3C3, 6'h00, 1'b0, 1, 18'h00C0C, 4'b0000);
        runOp("sra3",     OP_SRA, 18'h20000, 18'h00003, 6'h00, 1'b0, 4, 18'h3C000, 4'b0100);
        runOp("shl_sat",  OP_SHL, 18'h12345, 18'd25, 6'h00, 1'b0, 19, 18'h00000, 4'b1000);
        runOp("shl_zero", OP_SHL, 18'h2ABCD, 18'h00020, 6'h00, 1'b0, 1, 18'h2ABCD, 4'b0100);
        runOp("mul_big",  OP_MUL, 18'd1000, 18'd1000, 6'h00, 1'b0, 19, 18'h34240, 4'b0101);
        runOp("mul_fit",  OP_MUL, 18'd300, 18'd500, 6'h00, 1'b0, 19, 18'h249F0, 4'b0100);

        // Hold the consumer off and try to sneak in another request while DONE.
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 18'd2, 18'd3, 6'h00, 1'b0);
        waitValid(lat);
        checkOutput("bp_latency", 36'(lat), 36'd1);
        op       = OP_MUL;
        src1     = 18'd7;
        src2     = 18'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("bp_result", 36'(result), 36'd5);
            checkOutput("bp_hold", 36'({out_valid, in_ready, flag_z, flag_n, flag_c, flag_v}), 36'b100000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release", 36'({out_valid, in_ready}), 36'b01);
        checkOutput("bp_result_kept", 36'(result), 36'd5);
        @(posedge clk); #1;
        checkOutput("bp_no_ghost", 36'({out_valid, in_ready}), 36'b01);

        // Abort a multiply partway through.
        applyStimulus(OP_MUL, 18'd1000, 18'd1000, 6'h00, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_result", 36'(result), 36'h0);
        checkOutput("abort_flags", 36'({out_valid, in_ready, flag_z, flag_n, flag_c, flag_v}), 36'b010000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        checkOutput("abort_no_valid", 36'(seen_valid), 36'h0);
        runOp("and_after", OP_AND, 18'h0F0F0, 18'h3C3C3, 6'h00, 1'b0, 1, 18'h0C0C0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
